// File: rtl/text_pkg.sv
// Shared text-path definitions used by the score writer and the text overlay
// renderer: character codes, line geometry and the writer FSM encoding.
package text_pkg;

    localparam logic [6:0] ASCII_ZERO = 7'h30;  // font ROM code for '0'
    localparam logic [6:0] CHAR_BLANK = 7'h00;  // font ROM code for an empty cell
    localparam int         LINE_COLS  = 32;     // columns per text line

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_WRITE,
        S_DONE
    } state_t;

endpackage

// File: rtl/bin2bcd_step.sv
// One combinational double-dabble iteration.
//   bcd_in  : NUM_DIGITS packed BCD nibbles (LS nibble at bit 0)
//   bin_in  : remaining binary bits, MSB is shifted into the BCD field next
//   bcd_out : nibbles after the add-3 correction and a one-bit left shift
//   bin_out : binary register shifted left by one
module bin2bcd_step #(
    parameter int VALUE_W    = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic [NUM_DIGITS*4-1:0] bcd_in,
    input  logic [VALUE_W-1:0]      bin_in,
    output logic [NUM_DIGITS*4-1:0] bcd_out,
    output logic [VALUE_W-1:0]      bin_out
);

    logic [NUM_DIGITS*4-1:0] adj;
    logic                    unused_carry;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_nib
        assign adj[i*4 +: 4] = (bcd_in[i*4 +: 4] >= 4'd5) ? bcd_in[i*4 +: 4] + 4'd3
                                                          : bcd_in[i*4 +: 4];
    end

    // The top digit never exceeds 9 for a saturated input, so nothing is
    // lost off the top of the BCD field.
    assign unused_carry       = adj[NUM_DIGITS*4-1];
    assign {bcd_out, bin_out} = {adj[NUM_DIGITS*4-2:0], bin_in, 1'b0};

endmodule

// File: rtl/score_text_writer.sv
// Converts a binary score to decimal and writes the digits, MSD first, one
// per cycle into the text character RAM as font ROM codes.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : request, honoured only when idle
//   value, base_addr    : score and column of its most-significant digit
//   busy, done          : busy from the cycle after accept; done pulses once
//   wr_en/wr_addr/wr_data : registered text RAM write port
module score_text_writer
    import text_pkg::*;
#(
    parameter int VALUE_W    = 14,
    parameter int NUM_DIGITS = 4,
    parameter int ADDR_W     = 5,
    parameter int BLANK_LZ   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [VALUE_W-1:0] value,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [6:0]        wr_data
);

    localparam int BCD_W   = NUM_DIGITS * 4;
    localparam int CNT_W   = $clog2(VALUE_W + 1);
    localparam int IDX_W   = $clog2(NUM_DIGITS + 1);
    localparam int MAX_VAL = 10**NUM_DIGITS - 1;

    state_t             state;
    logic [BCD_W-1:0]   bcd, bcd_step;
    logic [VALUE_W-1:0] bin, bin_step;
    logic [CNT_W-1:0]   bit_cnt;
    logic [IDX_W-1:0]   idx;
    logic [ADDR_W-1:0]  base;
    logic               seen_nz;   // a nonzero digit has already been written

    logic               sat;
    logic [BCD_W-1:0]   cur_bcd;
    logic [IDX_W-1:0]   cur_idx;
    logic               cur_seen;
    logic [3:0]         cur_digit;
    logic [6:0]         cur_char;
    logic [ADDR_W-1:0]  cur_addr;
    int                 sh;

    bin2bcd_step #(
        .VALUE_W    (VALUE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_step (
        .bcd_in  (bcd),
        .bin_in  (bin),
        .bcd_out (bcd_step),
        .bin_out (bin_step)
    );

    assign sat = 32'(value) > 32'(MAX_VAL);

    // The first digit is emitted on the same edge as the last conversion
    // step so the write burst starts right after CONVERT; it therefore reads
    // the step result directly instead of the registered BCD value.
    always_comb begin
        cur_bcd  = bcd;
        cur_idx  = idx;
        cur_seen = seen_nz;
        if (state == S_CONVERT) begin
            cur_bcd  = bcd_step;
            cur_idx  = '0;
            cur_seen = 1'b0;
        end
        sh = 0;
        if (cur_idx < IDX_W'(NUM_DIGITS))
            sh = 4 * (NUM_DIGITS - 1 - int'(cur_idx));
        cur_digit = 4'(cur_bcd >> sh);
        cur_addr  = base + ADDR_W'(cur_idx);
        if (BLANK_LZ != 0 && !cur_seen && cur_digit == 4'd0 &&
            cur_idx != IDX_W'(NUM_DIGITS - 1))
            cur_char = CHAR_BLANK;
        else
            cur_char = ASCII_ZERO + {3'b000, cur_digit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            bcd     <= '0;
            bin     <= '0;
            bit_cnt <= '0;
            idx     <= '0;
            base    <= '0;
            seen_nz <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        bin     <= sat ? VALUE_W'(MAX_VAL) : value;
                        bcd     <= '0;
                        bit_cnt <= CNT_W'(VALUE_W);
                        base    <= base_addr;
                        idx     <= '0;
                        seen_nz <= 1'b0;
                        busy    <= 1'b1;
                        state   <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    bcd     <= bcd_step;
                    bin     <= bin_step;
                    bit_cnt <= bit_cnt - 1'b1;
                    if (bit_cnt == CNT_W'(1)) begin
                        wr_en   <= 1'b1;
                        wr_addr <= cur_addr;
                        wr_data <= cur_char;
                        seen_nz <= (cur_digit != 4'd0);
                        idx     <= IDX_W'(1);
                        state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (idx == IDX_W'(NUM_DIGITS)) begin
                        wr_en   <= 1'b0;
                        wr_addr <= '0;
                        wr_data <= '0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        wr_addr <= cur_addr;
                        wr_data <= cur_char;
                        seen_nz <= seen_nz | (cur_digit != 4'd0);
                        idx     <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_score_text_writer.sv
// Bench for score_text_writer: one instance with leading-zero blanking and one
// without, sharing inputs. A period-indexed expectation table is filled by a
// decimal-arithmetic model whenever a start is accepted; a negedge process
// compares both instances against it every cycle. Directed cases pin the
// model with literal write lists.
module tb_score_text_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [13:0] value = '0;
    logic [4:0]  base_addr = '0;

    logic        busy1, done1, we1;
    logic [4:0]  addr1;
    logic [6:0]  data1;
    logic        busy0, done0, we0;
    logic [4:0]  addr0;
    logic [6:0]  data0;

    score_text_writer #(.VALUE_W(14), .NUM_DIGITS(4), .ADDR_W(5), .BLANK_LZ(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .value(value), .base_addr(base_addr),
        .busy(busy1), .done(done1), .wr_en(we1), .wr_addr(addr1), .wr_data(data1));

    score_text_writer #(.VALUE_W(14), .NUM_DIGITS(4), .ADDR_W(5), .BLANK_LZ(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .value(value), .base_addr(base_addr),
        .busy(busy0), .done(done0), .wr_en(we0), .wr_addr(addr0), .wr_data(data0));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    localparam int MAXP = 4096;
    logic       e_busy [MAXP];
    logic       e_done [MAXP];
    logic       e_we   [MAXP];
    logic [4:0] e_addr [MAXP];
    logic [6:0] e_d1   [MAXP];
    logic [6:0] e_d0   [MAXP];
    int         free_at = 0;
    int         last_acc = 0;
    logic       chk_en = 1'b0;

    int log_p[$];
    int log_a[$];
    int log_d1[$];
    int log_d0[$];
    int done_p[$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s (period %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && cyc < MAXP) begin
            chk("busy", busy1, e_busy[cyc]);
            chk("done", done1, e_done[cyc]);
            chk("wr_en", we1, e_we[cyc]);
            chk("busy_nb", busy0, e_busy[cyc]);
            chk("done_nb", done0, e_done[cyc]);
            chk("wr_en_nb", we0, e_we[cyc]);
            if (e_we[cyc]) begin
                chk("wr_addr", addr1, e_addr[cyc]);
                chk("wr_data", data1, e_d1[cyc]);
                chk("wr_addr_nb", addr0, e_addr[cyc]);
                chk("wr_data_nb", data0, e_d0[cyc]);
            end
            if (we1) begin
                log_p.push_back(cyc);
                log_a.push_back(int'(addr1));
                log_d1.push_back(int'(data1));
                log_d0.push_back(int'(data0));
            end
            if (done1) done_p.push_back(cyc);
        end
    end

    // Accept at the edge that begins period a: that period is cycle 1.
    task automatic model_accept(input int a, input int v, input int b);
        int sat;
        int pw[4];
        int d;
        pw = '{1000, 100, 10, 1};
        sat = (v > 9999) ? 9999 : v;
        last_acc = a;
        free_at = a + 20;
        for (int p = a; p <= a + 18 && p < MAXP; p++) e_busy[p] = 1'b1;
        if (a + 18 < MAXP) e_done[a + 18] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (a + 14 + i < MAXP) begin
                d = (sat / pw[i]) % 10;
                e_we[a + 14 + i]   = 1'b1;
                e_addr[a + 14 + i] = 5'((b + i) % 32);
                e_d0[a + 14 + i]   = 7'(48 + d);
                e_d1[a + 14 + i]   = (i < 3 && sat < pw[i]) ? 7'h00 : 7'(48 + d);
            end
        end
    endtask

    task automatic step(input logic s, input int v, input int b);
        @(negedge clk);
        #2;
        start = s;
        value = 14'(v);
        base_addr = 5'(b);
        if (s && rst_n && cyc + 1 >= free_at) model_accept(cyc + 1, v, b);
    endtask

    task automatic clear_logs();
        log_p.delete(); log_a.delete(); log_d1.delete(); log_d0.delete(); done_p.delete();
    endtask

    task automatic directed(input int v, input int b, input int ea[4], input int ed1[4],
                            input int ed0[4]);
        int a;
        clear_logs();
        step(1'b1, v, b);
        a = last_acc;
        repeat (24) step(1'b0, 0, 0);
        chk("write_count", log_p.size(), 4);
        if (log_p.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("lit_cycle", log_p[i] - a + 1, 15 + i);
                chk("lit_addr", log_a[i], ea[i]);
                chk("lit_data", log_d1[i], ed1[i]);
                chk("lit_data_nb", log_d0[i], ed0[i]);
            end
        end
        chk("done_count", done_p.size(), 1);
        if (done_p.size() == 1) chk("done_cycle", done_p[0] - a + 1, 19);
    endtask

    initial begin
        int a;
        for (int p = 0; p < MAXP; p++) begin
            e_busy[p] = 1'b0; e_done[p] = 1'b0; e_we[p] = 1'b0;
            e_addr[p] = '0; e_d1[p] = '0; e_d0[p] = '0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_wr_en", we1, 0);
        chk("rst_wr_addr", addr1, 0);
        chk("rst_wr_data", data1, 0);
        chk("rst_wr_en_nb", we0, 0);
        #2;
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (2) step(1'b0, 0, 0);

        directed(1234, 5,  '{5, 6, 7, 8},    '{'h31, 'h32, 'h33, 'h34}, '{'h31, 'h32, 'h33, 'h34});
        directed(7,    0,  '{0, 1, 2, 3},    '{'h00, 'h00, 'h00, 'h37}, '{'h30, 'h30, 'h30, 'h37});
        directed(0,    12, '{12, 13, 14, 15}, '{'h00, 'h00, 'h00, 'h30}, '{'h30, 'h30, 'h30, 'h30});
        directed(12000, 3, '{3, 4, 5, 6},    '{'h39, 'h39, 'h39, 'h39}, '{'h39, 'h39, 'h39, 'h39});
        directed(5678, 30, '{30, 31, 0, 1},  '{'h35, 'h36, 'h37, 'h38}, '{'h35, 'h36, 'h37, 'h38});
        directed(1050, 9,  '{9, 10, 11, 12}, '{'h31, 'h30, 'h35, 'h30}, '{'h31, 'h30, 'h35, 'h30});

        // Start pulse while busy is dropped
        clear_logs();
        step(1'b1, 1234, 5);
        repeat (8) step(1'b0, 0, 0);
        step(1'b1, 999, 0);
        repeat (20) step(1'b0, 0, 0);
        chk("ignored_start_writes", log_p.size(), 4);
        chk("ignored_start_dones", done_p.size(), 1);

        // Start held high: back-to-back conversions 20 cycles apart
        clear_logs();
        repeat (60) step(1'b1, 4321, 2);
        repeat (23) step(1'b0, 0, 0);
        chk("held_start_dones", done_p.size(), 3);
        if (done_p.size() == 3) begin
            chk("held_start_gap1", done_p[1] - done_p[0], 20);
            chk("held_start_gap2", done_p[2] - done_p[1], 20);
        end

        // Reset during write cycle 16
        clear_logs();
        step(1'b1, 1234, 5);
        a = last_acc;
        while (cyc < a + 15) step(1'b0, 0, 0);
        chk("pre_reset_wr_en", we1, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_wr_en", we1, 0);
        chk("mid_reset_busy", busy1, 0);
        chk("mid_reset_wr_en_nb", we0, 0);
        chk("mid_reset_busy_nb", busy0, 0);
        for (int p = cyc + 1; p < MAXP; p++) begin
            e_busy[p] = 1'b0; e_done[p] = 1'b0; e_we[p] = 1'b0;
        end
        free_at = 0;
        repeat (3) step(1'b0, 0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (10) step(1'b0, 0, 0);
        chk("reset_partial_writes", log_p.size(), 2);
        chk("reset_no_done", done_p.size(), 0);
        directed(1234, 5, '{5, 6, 7, 8}, '{'h31, 'h32, 'h33, 'h34}, '{'h31, 'h32, 'h33, 'h34});

        // Randomized traffic against the model
        repeat (500) begin
            int v;
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 120))
                                            : int'($urandom_range(0, 16383));
            step($urandom_range(0, 5) == 0, v, int'($urandom_range(0, 31)));
        end
        repeat (25) step(1'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
